// File: rtl/aes_stream_ctrl.sv
// -----------------------------------------------------------------------------
// aes_stream_ctrl
//   Byte-stream front end for the multicycle AES core. A command byte ('E' or
//   'D') followed by 16 data bytes is collected from the rx stream into a
//   128-bit block. The block is handed to the core with a one-cycle load pulse.
//   When the core's busy falls, its result is captured and returned as 16 bytes
//   (MSB byte first) on the tx stream. trigger_o brackets the core's busy window
//   for scope capture.
//
// Optional feature (macro AES_STREAM_CYCLE_COUNT_EN):
//   Counts the core busy cycles (16-bit, saturating) and appends the count as
//   two extra tx bytes (high byte first), giving 18 bytes per response.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   rx_valid_i/rx_data_i     input byte stream (rx_ready_o back-pressure)
//   tx_valid_o/tx_data_o     output byte stream (tx_ready_i back-pressure)
//   core_load_o/core_dec_o   load pulse and decrypt select to the core
//   core_data_o              assembled block to the core
//   core_busy_i/core_data_i  core busy flag and result
//   trigger_o                scope trigger, high from load through capture
// -----------------------------------------------------------------------------
module aes_stream_ctrl #(
  parameter logic [7:0] CMD_ENC     = 8'h45,
  parameter logic [7:0] CMD_DEC     = 8'h44,
  parameter int         START_DELAY = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_valid_i,
  input  logic [7:0]   rx_data_i,
  output logic         rx_ready_o,
  output logic         tx_valid_o,
  output logic [7:0]   tx_data_o,
  input  logic         tx_ready_i,
  output logic         core_load_o,
  output logic         core_dec_o,
  output logic [127:0] core_data_o,
  input  logic         core_busy_i,
  input  logic [127:0] core_data_i,
  output logic         trigger_o
);

  localparam int DLY_W = $clog2(START_DELAY + 1);
`ifdef AES_STREAM_CYCLE_COUNT_EN
  localparam logic [4:0] TX_LAST = 5'd17;
`else
  localparam logic [4:0] TX_LAST = 5'd15;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RX   = 3'd1,
    S_LOAD = 3'd2,
    S_WAIT = 3'd3,
    S_TX   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_rx_ready;
  logic               r_tx_valid;
  logic [7:0]         r_tx_data;
  logic               r_core_load;
  logic               r_core_dec;
  logic [127:0]       r_core_data;
  logic               r_trigger;
  logic               r_dec;
  logic [4:0]         r_cnt;
  logic [119:0]       r_shift;
  logic [127:0]       r_result;
  logic [DLY_W-1:0]   r_dly;
  logic [15:0]        w_cyc;
  logic               w_rx_fire;
  logic               w_tx_fire;
  logic               w_cmd_ok;
  logic               w_dly_done;
  logic               w_capture;

`ifdef AES_STREAM_CYCLE_COUNT_EN
  logic [15:0]        r_cyc;
  assign w_cyc = r_cyc;
`else
  assign w_cyc = 16'h0000;
`endif

  // Picks tx byte idx: 0..15 from the result (MSB byte first), 16/17 from the count.
  function automatic logic [7:0] f_tx_byte(input logic [127:0] i_res,
                                           input logic [15:0]  i_cyc,
                                           input logic [4:0]   i_idx);
    logic [7:0] v_byte;
    if (!i_idx[4]) begin
      v_byte = i_res[{~i_idx[3:0], 3'b000} +: 8];
    end else if (i_idx == 5'd16) begin
      v_byte = i_cyc[15:8];
    end else begin
      v_byte = i_cyc[7:0];
    end
    return v_byte;
  endfunction

  assign w_rx_fire  = rx_valid_i && r_rx_ready;
  assign w_tx_fire  = r_tx_valid && tx_ready_i;
  assign w_cmd_ok   = w_rx_fire && ((rx_data_i == CMD_ENC) || (rx_data_i == CMD_DEC));
  assign w_dly_done = (r_dly == DLY_W'(START_DELAY));

  // Next-state decode; w_capture marks the cycle the core result is taken.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_ok) w_state_nxt = S_RX;
        else          w_state_nxt = S_IDLE;
      end
      S_RX: begin
        if (w_rx_fire && (r_cnt == 5'd15)) w_state_nxt = S_LOAD;
        else                               w_state_nxt = S_RX;
      end
      S_LOAD: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // busy is only meaningful once the core has had time to raise it
        if (w_dly_done && !core_busy_i) begin
          w_capture   = 1'b1;
          w_state_nxt = S_TX;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_TX: begin
        if (w_tx_fire && (r_cnt == TX_LAST)) w_state_nxt = S_IDLE;
        else                                 w_state_nxt = S_TX;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, datapath and registered outputs (decoded from next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rx_ready  <= 1'b1;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_core_load <= 1'b0;
      r_core_dec  <= 1'b0;
      r_core_data <= 128'h0;
      r_trigger   <= 1'b0;
      r_dec       <= 1'b0;
      r_cnt       <= 5'd0;
      r_shift     <= 120'h0;
      r_result    <= 128'h0;
      r_dly       <= '0;
`ifdef AES_STREAM_CYCLE_COUNT_EN
      r_cyc       <= 16'h0000;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_rx_ready  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RX);
      r_tx_valid  <= (w_state_nxt == S_TX);
      r_core_load <= (w_state_nxt == S_LOAD);
      r_core_dec  <= (w_state_nxt == S_LOAD) ? r_dec : 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_ok) begin
            r_dec <= (rx_data_i == CMD_DEC);
            r_cnt <= 5'd0;
          end
        end
        S_RX: begin
          if (w_rx_fire) begin
            r_shift <= {r_shift[111:0], rx_data_i};
            if (r_cnt == 5'd15) begin
              // core_data_o only changes here so it stays stable between loads
              r_core_data <= {r_shift, rx_data_i};
              r_trigger   <= 1'b1;
              r_cnt       <= 5'd0;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        S_LOAD: begin
          r_dly <= '0;
`ifdef AES_STREAM_CYCLE_COUNT_EN
          r_cyc <= 16'h0000;
`endif
        end
        S_WAIT: begin
          if (!w_dly_done) r_dly <= r_dly + DLY_W'(1);
`ifdef AES_STREAM_CYCLE_COUNT_EN
          if (core_busy_i && (r_cyc != 16'hFFFF)) r_cyc <= r_cyc + 16'd1;
`endif
          if (w_capture) begin
            r_result  <= core_data_i;
            r_tx_data <= core_data_i[127:120];
            r_trigger <= 1'b0;
            r_cnt     <= 5'd0;
          end
        end
        S_TX: begin
          if (w_tx_fire) begin
            if (r_cnt == TX_LAST) begin
              r_cnt     <= 5'd0;
              r_tx_data <= 8'h00;
            end else begin
              r_cnt     <= r_cnt + 5'd1;
              r_tx_data <= f_tx_byte(r_result, w_cyc, r_cnt + 5'd1);
            end
          end
        end
        default: begin
          r_cnt <= 5'd0;
        end
      endcase
    end
  end

  assign rx_ready_o  = r_rx_ready;
  assign tx_valid_o  = r_tx_valid;
  assign tx_data_o   = r_tx_data;
  assign core_load_o = r_core_load;
  assign core_dec_o  = r_core_dec;
  assign core_data_o = r_core_data;
  assign trigger_o   = r_trigger;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_stream_ctrl
//   Directed bench for aes_stream_ctrl. A small behavioural core answers the
//   FIPS-197 AES-128 example vector (key 000102..0f) in both directions with a
//   52-cycle busy window; any other block comes back inverted.
// -----------------------------------------------------------------------------
module tb_aes_stream_ctrl;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_STREAM_CYCLE_COUNT_EN
  localparam int NB = 18;
`else
  localparam int NB = 16;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx_valid_i = 1'b0;
  logic [7:0]   rx_data_i = 8'h00;
  logic         rx_ready_o;
  logic         tx_valid_o;
  logic [7:0]   tx_data_o;
  logic         tx_ready_i = 1'b1;
  logic         core_load_o;
  logic         core_dec_o;
  logic [127:0] core_data_o;
  logic         core_busy_i = 1'b0;
  logic [127:0] core_data_i = 128'h0;
  logic         trigger_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aes_stream_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .rx_ready_o  (rx_ready_o),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .core_load_o (core_load_o),
    .core_dec_o  (core_dec_o),
    .core_data_o (core_data_o),
    .core_busy_i (core_busy_i),
    .core_data_i (core_data_i),
    .trigger_o   (trigger_o)
  );

  // Behavioural core: known-answer lookup, busy high for 52 cycles after load.
  function automatic logic [127:0] core_fn(input logic dec, input logic [127:0] d);
    if (!dec && d == PT) return CT;
    else if (dec && d == CT) return PT;
    else return ~d;
  endfunction

  logic [127:0] m_result = 128'h0;
  int           m_left = 0;
  int           load_count = 0;
  int           trig_cycles = 0;

  always @(posedge clk) begin
    if (core_load_o) begin
      core_busy_i <= 1'b1;
      m_left      <= 51;
      load_count  <= load_count + 1;
      m_result    <= core_fn(core_dec_o, core_data_o);
    end else if (core_busy_i) begin
      if (m_left == 0) begin
        core_busy_i <= 1'b0;
        core_data_i <= m_result;
      end else begin
        m_left <= m_left - 1;
      end
    end
    if (trigger_o) trig_cycles <= trig_cycles + 1;
  end

  function automatic logic [7:0] exp_byte(input logic [127:0] blk, input int i);
    logic [7:0] b;
    if (i < 16) b = blk[8*(15-i) +: 8];
    else if (i == 16) b = 8'h00;
    else b = 8'h34;
    return b;
  endfunction

  // Offers one byte; returns at the negedge after it transferred (valid left high).
  task automatic send_byte(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    for (int k = 0; k < 1000; k++) begin
      if (rx_ready_o) break;
      @(negedge clk);
    end
    if (!rx_ready_o) begin
      n_cmp++; n_bad++;
      $display("FAIL rx_timeout: rx_ready_o=%0b required 1", rx_ready_o);
    end
    @(negedge clk);
  endtask

  task automatic send_block(input logic [7:0] cmd, input logic [127:0] blk);
    send_byte(cmd);
    for (int i = 0; i < 16; i++) send_byte(blk[8*(15-i) +: 8]);
    rx_valid_i = 1'b0;
  endtask

  // Collects NB tx bytes; reports held-data violations and rx_ready leaks.
  task automatic recv(input bit rnd, output logic [7:0] got [NB], output int n_got,
                      output int n_unstable, output int n_rxleak);
    bit         stalled = 1'b0;
    logic [7:0] prev = 8'h00;
    n_got = 0; n_unstable = 0; n_rxleak = 0;
    for (int i = 0; i < NB; i++) got[i] = 8'h00;
    for (int cyc = 0; cyc < 2000 && n_got < NB; cyc++) begin
      tx_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled && (!tx_valid_o || tx_data_o != prev)) n_unstable++;
      if (rx_ready_o) n_rxleak++;
      stalled = tx_valid_o && !tx_ready_i;
      prev    = tx_data_o;
      if (tx_valid_o && tx_ready_i) begin
        got[n_got] = tx_data_o;
        n_got++;
      end
      @(negedge clk);
    end
    tx_ready_i = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (rx_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_rx_ready: got %b required 1", rx_ready_o); end
    n_cmp++; if (tx_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_tx_valid: got %b required 0", tx_valid_o); end
    n_cmp++; if (tx_data_o !== 8'h00) begin n_bad++; $display("FAIL rst_tx_data: got %h required 00", tx_data_o); end
    n_cmp++; if (core_load_o !== 1'b0) begin n_bad++; $display("FAIL rst_load: got %b required 0", core_load_o); end
    n_cmp++; if (core_dec_o !== 1'b0) begin n_bad++; $display("FAIL rst_dec: got %b required 0", core_dec_o); end
    n_cmp++; if (core_data_o !== 128'h0) begin n_bad++; $display("FAIL rst_core_data: got %h required 0", core_data_o); end
    n_cmp++; if (trigger_o !== 1'b0) begin n_bad++; $display("FAIL rst_trigger: got %b required 0", trigger_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Full transaction with load-cycle checks and response byte checks.
  task automatic run_and_check(input string nm, input logic [7:0] cmd, input logic [127:0] blk,
                               input logic [127:0] exp, input bit rnd, input bit hold);
    logic [7:0] got [NB];
    int n_got, n_unst, n_leak, l0, t0;
    l0 = load_count; t0 = trig_cycles;
    send_block(cmd, blk);
    n_cmp++; if (core_load_o !== 1'b1) begin n_bad++; $display("FAIL %s_load: got %b required 1", nm, core_load_o); end
    n_cmp++; if (core_dec_o !== (cmd == 8'h44)) begin n_bad++; $display("FAIL %s_dec: got %b required %b", nm, core_dec_o, cmd == 8'h44); end
    n_cmp++; if (core_data_o !== blk) begin n_bad++; $display("FAIL %s_core_data: got %h required %h", nm, core_data_o, blk); end
    if (hold) begin rx_valid_i = 1'b1; rx_data_i = 8'h00; end
    recv(rnd, got, n_got, n_unst, n_leak);
    rx_valid_i = 1'b0;
    n_cmp++; if (n_got !== NB) begin n_bad++; $display("FAIL %s_nbytes: got %0d required %0d", nm, n_got, NB); end
    for (int i = 0; i < NB; i++) begin
      n_cmp++;
      if (got[i] !== exp_byte(exp, i)) begin n_bad++; $display("FAIL %s_byte%0d: got %h required %h", nm, i, got[i], exp_byte(exp, i)); end
    end
    n_cmp++; if (n_unst !== 0) begin n_bad++; $display("FAIL %s_tx_hold: got %0d unstable cycles required 0", nm, n_unst); end
    n_cmp++; if (n_leak !== 0) begin n_bad++; $display("FAIL %s_rx_stall: got %0d ready cycles required 0", nm, n_leak); end
    n_cmp++; if (rx_ready_o !== 1'b1 || tx_valid_o !== 1'b0) begin n_bad++; $display("FAIL %s_idle: got rdy=%b vld=%b required 1 0", nm, rx_ready_o, tx_valid_o); end
    n_cmp++; if (load_count - l0 !== 1) begin n_bad++; $display("FAIL %s_loads: got %0d required 1", nm, load_count - l0); end
    n_cmp++; if (trig_cycles - t0 !== 54) begin n_bad++; $display("FAIL %s_trig_len: got %0d required 54", nm, trig_cycles - t0); end
  endtask

  task automatic test_encrypt;
    run_and_check("enc", 8'h45, PT, CT, 1'b0, 1'b0);
  endtask

  task automatic test_decrypt;
    run_and_check("dec", 8'h44, CT, PT, 1'b0, 1'b0);
  endtask

  task automatic test_drop;
    int l0;
    l0 = load_count;
    send_byte(8'h00);
    send_byte(8'h7f);
    rx_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (load_count - l0 !== 0) begin n_bad++; $display("FAIL drop_noload: got %0d required 0", load_count - l0); end
    n_cmp++; if (rx_ready_o !== 1'b1) begin n_bad++; $display("FAIL drop_ready: got %b required 1", rx_ready_o); end
    run_and_check("drop", 8'h45, PT, CT, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_and_check("bp", 8'h45, PT, CT, 1'b1, 1'b1);
    run_and_check("bp2", 8'h45, 128'h0f0e0d0c0b0a09080706050403020100, ~128'h0f0e0d0c0b0a09080706050403020100, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid;
    int l0;
    l0 = load_count;
    send_byte(8'h45);
    for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i));
    rx_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (trigger_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_trigger: got %b required 0", trigger_o); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (load_count - l0 !== 0) begin n_bad++; $display("FAIL rstmid_noload: got %0d required 0", load_count - l0); end
    // reset while the core is busy: trigger must drop at once
    send_block(8'h44, CT);
    repeat (10) @(negedge clk);
    n_cmp++; if (trigger_o !== 1'b1) begin n_bad++; $display("FAIL rstwait_trig_hi: got %b required 1", trigger_o); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (trigger_o !== 1'b0) begin n_bad++; $display("FAIL rstwait_trigger: got %b required 0", trigger_o); end
    n_cmp++; if (rx_ready_o !== 1'b1) begin n_bad++; $display("FAIL rstwait_ready: got %b required 1", rx_ready_o); end
    repeat (60) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_and_check("rstmid", 8'h45, PT, CT, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_encrypt;
    test_decrypt;
    test_drop;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
